// File: rtl/ram_bus_arbiter_pkg.sv
// ram_arb_pkg: types and constants shared by the RAM bus arbiter.
//   ADDR_W / DATA_W : RAM address and data widths (256 x 8 RAM)
//   state_t         : arbiter sequencing states
//   cmd_t           : command captured from the winning requester
package ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: requester-side and RAM-side signals of the arbiter.
//   Requester side : req, req_we, req_addr, req_wdata (to arbiter)
//                    gnt, rvalid, rdata, busy (from arbiter)
//   RAM side       : mem_addr, mem_wdata, mem_rwn (from arbiter)
//                    mem_rdata (combinational RAM read data, to arbiter)
// Modports: slave = the arbiter, master = the environment around it.
interface ram_bus_arbiter_if #(
    parameter int NREQ = 2
) ();
    import ram_arb_pkg::*;

    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             gnt;
    logic [NREQ-1:0]             rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_rwn;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_rwn
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_rwn
    );

endinterface

// File: rtl/ram_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req_i     : request vector
//   last_i    : index of the most recently granted requester
//   winner_o  : first set request searching upward from last_i+1 (mod NREQ)
//   any_req_o : at least one request is set
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_req_o
);

    logic [IDX_W-1:0] idx_v;
    logic             found_v;

    always_comb begin
        winner_o  = '0;
        any_req_o = |req_i;
        found_v   = 1'b0;
        idx_v     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = IDX_W'((int'(last_i) + k) % NREQ);
            if (!found_v && req_i[idx_v]) begin
                winner_o = idx_v;
                found_v  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one 256x8 single-port RAM between NREQ requesters.
// Round-robin arbitration; each granted command takes one RAM access cycle
// followed by one recovery cycle, so one access completes every 3 cycles.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : ram_bus_arbiter_if.slave (requester handshake + RAM port)
// Optional build macro RAM_ARB_STATS_EN adds:
//   stats_clr  : synchronous clear of the grant counters
//   grant_cnt  : per-requester saturating 16-bit grant counters
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; the winning command is latched on exit
// ACCESS  | RAM driven with the command; read data captured on exit
// RECOVER | RAM back to read/idle; rvalid pulses here for reads
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_bus_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
    ,input  logic                  stats_clr
    ,output logic [NREQ-1:0][15:0] grant_cnt
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  last_q,      last_d;
    logic [IDX_W-1:0]  owner_q,     owner_d;
    cmd_t              cmd_q,       cmd_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic [NREQ-1:0]   rvalid_q,    rvalid_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rwn_q,   mem_rwn_d;

    logic [IDX_W-1:0]  winner;
    logic              any_req;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i     (bus.req),
        .last_i    (last_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            owner_q     <= '0;
            cmd_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rwn_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rwn_q   <= mem_rwn_d;
        end
    end

    // The RAM port is loaded on the IDLE->ACCESS edge so the access
    // happens in the same cycle as the grant pulse.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rwn_d   = mem_rwn_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cmd_d.we      = bus.req_we[winner];
                    cmd_d.addr    = bus.req_addr[winner];
                    cmd_d.wdata   = bus.req_wdata[winner];
                    owner_d       = winner;
                    last_d        = winner;
                    gnt_d[winner] = 1'b1;
                    busy_d        = 1'b1;
                    mem_addr_d    = bus.req_addr[winner];
                    mem_rwn_d     = ~bus.req_we[winner];
                    if (bus.req_we[winner]) begin
                        mem_wdata_d = bus.req_wdata[winner];
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_d = cmd_q.addr;
                if (cmd_q.we) begin
                    mem_wdata_d = cmd_q.wdata;
                end else begin
                    rdata_d           = bus.mem_rdata;
                    rvalid_d[owner_q] = 1'b1;
                end
                mem_rwn_d = 1'b1;
                state_d   = RECOVER;
            end
            RECOVER: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                mem_rwn_d = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rwn   = mem_rwn_q;

`ifdef RAM_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt_q;

    // Clear has priority over a grant counted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else if (stats_clr) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;
    import ram_arb_pkg::*;

    localparam int NREQ = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_bus_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [NREQ-1:0][15:0] grant_cnt;
`endif

    ram_bus_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RAM_ARB_STATS_EN
        ,.stats_clr (stats_clr)
        ,.grant_cnt (grant_cnt)
`endif
    );

    // 256x8 RAM: combinational read, write on the clock edge closing a write cycle
    logic [7:0] ram [256];
    bit         ram_init = 1'b0;
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram_init <= 1'b1;
        end else if (!bus.mem_rwn) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked by the edge at
    // which it was granted. Edge g+1 completes the RAM access, the next
    // request is sampled no earlier than edge g+3.
    int              e;
    int              g_edge;
    int              m_last;
    int              m_owner;
    bit              m_we;
    logic [7:0]      m_addr, m_wdata;
    logic [7:0]      mram [256];
    int              m_cnt [NREQ];
    logic [NREQ-1:0] x_gnt, x_rvalid;
    logic [7:0]      x_rdata, x_addr, x_wdata;
    logic            x_busy, x_rwn;

    task automatic model_reset();
        g_edge   = e - 100;
        m_last   = NREQ - 1;
        x_gnt    = '0;
        x_rvalid = '0;
        x_rdata  = 8'h00;
        x_addr   = 8'h00;
        x_wdata  = 8'h00;
        x_busy   = 1'b0;
        x_rwn    = 1'b1;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge();
        int d;
        d        = e - g_edge;
        x_gnt    = '0;
        x_rvalid = '0;
        x_rwn    = 1'b1;
        x_busy   = 1'b0;
`ifdef RAM_ARB_STATS_EN
        if (stats_clr) begin
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (d == 1 && m_cnt[m_owner] < 65535) begin
            m_cnt[m_owner]++;
        end
`endif
        if (d == 1) begin
            x_busy = 1'b1;
            if (m_we) mram[m_addr] = m_wdata;
            else begin
                x_rdata           = mram[m_addr];
                x_rvalid[m_owner] = 1'b1;
            end
        end else if (d >= 3 && bus.req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (bus.req[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    break;
                end
            end
            m_last           = m_owner;
            g_edge           = e;
            m_we             = bus.req_we[m_owner];
            m_addr           = bus.req_addr[m_owner];
            m_wdata          = bus.req_wdata[m_owner];
            x_gnt[m_owner]   = 1'b1;
            x_busy           = 1'b1;
            x_rwn            = ~m_we;
            x_addr           = m_addr;
            if (m_we) x_wdata = m_wdata;
        end
        e++;
    endtask

    task automatic check_all();
        chk("gnt",       32'(bus.gnt),       32'(x_gnt));
        chk("rvalid",    32'(bus.rvalid),    32'(x_rvalid));
        chk("rdata",     32'(bus.rdata),     32'(x_rdata));
        chk("busy",      32'(bus.busy),      32'(x_busy));
        chk("mem_rwn",   32'(bus.mem_rwn),   32'(x_rwn));
        chk("mem_addr",  32'(bus.mem_addr),  32'(x_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(x_wdata));
`ifdef RAM_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        bus.req[i]       = 1'b1;
        bus.req_we[i]    = we;
        bus.req_addr[i]  = addr;
        bus.req_wdata[i] = wdata;
    endtask

    task automatic clr_req(input int i);
        bus.req[i] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < NREQ; i++) clr_req(i);
        repeat (3) tick();
    endtask

    logic [7:0] addr_pool [8] = '{8'h00, 8'h10, 8'h11, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hFE};
    bit         just_gnt  [NREQ];

    task automatic new_cmd(input int i);
        set_req(i, 1'($urandom_range(1, 0)), addr_pool[$urandom_range(7, 0)], 8'($urandom));
    endtask

    // Requesters hold their command until granted and act in the cycle after gnt
    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (just_gnt[i]) begin
                just_gnt[i] = 1'b0;
                if ($urandom_range(1, 0) == 1) new_cmd(i);
                else clr_req(i);
            end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
                new_cmd(i);
            end
            if (bus.gnt[i]) just_gnt[i] = 1'b1;
        end
`ifdef RAM_ARB_STATS_EN
        stats_clr = ($urandom_range(15, 0) == 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_g, got0, got1, pulses;
        int g_idx [6];
        int g_e   [6];

        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        e             = 0;
        for (int i = 0; i < 256; i++) mram[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < NREQ; i++) just_gnt[i] = 1'b0;
        #2;
        do_reset();

        // write then read, single requester
        set_req(0, 1'b1, 8'h10, 8'hA5);
        tick();
        chk("wr_gnt", 32'(bus.gnt), 32'h1);
        chk("wr_rwn_low", 32'(bus.mem_rwn), 32'h0);
        clr_req(0);
        tick();
        chk("wr_rwn_high", 32'(bus.mem_rwn), 32'h1);
        tick();
        set_req(0, 1'b0, 8'h10, 8'h00);
        tick();
        chk("rd_gnt", 32'(bus.gnt), 32'h1);
        clr_req(0);
        tick();
        chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rd_data", 32'(bus.rdata), 32'hA5);
        drain();

        // contention from reset: grants alternate starting at requester 0
        do_reset();
        set_req(0, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b0, 8'h11, 8'h00);
        n_g = 0;
        for (int k = 0; k < 30 && n_g < 6; k++) begin
            tick();
            if (bus.gnt != '0) begin
                g_idx[n_g] = bus.gnt[1] ? 1 : 0;
                g_e[n_g]   = e;
                n_g++;
            end
        end
        chk("cont_count", 32'(n_g), 32'd6);
        for (int k = 0; k < n_g; k++) begin
            chk("cont_order", 32'(g_idx[k]), 32'(k % 2));
            if (k > 0) chk("cont_spacing", 32'(g_e[k] - g_e[k-1]), 32'd3);
        end
        drain();

        // boundary address 8'hFF, concurrent read of 8'h00
        set_req(1, 1'b1, 8'hFF, 8'hFF);
        tick();
        chk("bnd_wr_gnt", 32'(bus.gnt), 32'h2);
        clr_req(1);
        tick();
        tick();
        set_req(0, 1'b0, 8'hFF, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        got0 = 0;
        got1 = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.rvalid[0]) begin chk("bnd_rd_ff", 32'(bus.rdata), 32'hFF); got0++; end
            if (bus.rvalid[1]) begin chk("bnd_rd_00", 32'(bus.rdata), 32'h5A); got1++; end
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) clr_req(i);
        end
        chk("bnd_rvalid0", 32'(got0), 32'd1);
        chk("bnd_rvalid1", 32'(got1), 32'd1);
        drain();

        // reset in the middle of a write access
        set_req(1, 1'b1, 8'h20, 8'h77);
        tick();
        chk("acc_wr_active", 32'(bus.mem_rwn), 32'h0);
        clr_req(1);
        #2;
        do_reset();
        set_req(0, 1'b0, 8'h20, 8'h00);
        set_req(1, 1'b0, 8'h21, 8'h00);
        tick();
        chk("rst_first_gnt", 32'(bus.gnt), 32'h1);
        drain();

        // no requests for 20 cycles
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.gnt != '0 || bus.rvalid != '0 || bus.busy || !bus.mem_rwn) pulses++;
        end
        chk("idle_quiet", 32'(pulses), 32'd0);

`ifdef RAM_ARB_STATS_EN
        do_reset();
        set_req(1, 1'b1, 8'h30, 8'h3C);
        n_g = 0;
        for (int k = 0; k < 30 && n_g < 5; k++) begin
            tick();
            if (bus.gnt[1]) n_g++;
        end
        clr_req(1);
        tick();
        chk("stat_cnt1", 32'(grant_cnt[1]), 32'd5);
        tick();
        set_req(0, 1'b0, 8'h30, 8'h00);
        got0 = 0;
        for (int k = 0; k < 6 && got0 == 0; k++) begin
            tick();
            if (bus.gnt[0]) got0 = 1;
        end
        chk("stat_gnt0_seen", 32'(got0), 32'd1);
        clr_req(0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stat_clr0", 32'(grant_cnt[0]), 32'd0);
        chk("stat_clr1", 32'(grant_cnt[1]), 32'd0);
        drain();
`endif

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            drive_random();
            tick();
        end
`ifdef RAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares one 256x8 single-port RAM between NREQ requesters.
- Round-robin arbitration selects one requester at a time.
- Each granted command is sequenced onto the RAM port: 8-bit address, 8-bit data, and RWn (1 = read, 0 = write).
- Captured read data is returned to the owning requester.
- Sits between bus masters and the RAM, and replaces the masters' direct task-driven access to the RAM bus.

Parameters:
- NREQ, 2, number of requesters (2..4).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ x ADDR_W  access address.
- req_wdata  in  NREQ x DATA_W  write data.
- gnt  out  NREQ  one-cycle grant pulse, one-hot.
- rvalid  out  NREQ  one-cycle read-data-valid pulse, one-hot.
- rdata  out  DATA_W  read data; valid when any rvalid bit is high.
- busy  out  1  arbiter is not in IDLE.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rwn  out  1  RAM RWn; 1 = read/idle, 0 = write.
- mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - gnt=0, rvalid=0, rdata=0, busy=0.
  - mem_addr=0, mem_wdata=0, mem_rwn=1.
  - State = IDLE; RR pointer last=NREQ-1, so req[0] wins first.
- FSM states: IDLE, ACCESS, RECOVER. All outputs are registered.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise winner = first set bit searching from last+1 modulo NREQ.
  - Next cycle: gnt[winner]=1, cmd latched {we, addr, wdata}, last=winner, state ACCESS, busy=1.
- ACCESS (exactly 1 cycle):
  - mem_addr=cmd.addr and mem_rwn=~cmd.we.
  - mem_wdata=cmd.wdata for writes.
  - For reads, mem_rdata is sampled into rdata at the closing edge.
  - Next state RECOVER.
- RECOVER (exactly 1 cycle):
  - mem_rwn=1; mem_addr and mem_wdata hold.
  - For reads, rvalid[owner]=1; for writes, rvalid stays 0.
  - Next state IDLE; busy=0.
- Latency:
  - req sampled in cycle N -> gnt in N+1 -> RAM write or read in N+1 -> rvalid in N+2.
  - Throughput: one access per 3 cycles.
- Requester rules:
  - Hold req, req_we, req_addr and req_wdata stable from assertion until the gnt cycle.
  - Deassert req in the cycle after gnt, or keep it high to queue another access.
- req is ignored in ACCESS and RECOVER; no request is ever dropped, it waits.
- Simultaneous requests: round-robin. Under continuous contention with NREQ=2, grants alternate 0,1,0,1.
- A single persistent requester is re-granted every 3 cycles.
- mem_rwn=0 lasts exactly one cycle per write and never in two consecutive cycles.
- Reset mid-ACCESS aborts the cycle: mem_rwn returns to 1 immediately, no rvalid is issued, and the write may not complete.
- Address wrap: none. The address is passed through unmodified; 8'hFF is legal.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and output grant_cnt (NREQ x 16).
  - Each counter increments on its gnt pulse and saturates at 16'hFFFF.
  - Counters clear on reset or on synchronous stats_clr; clear wins over a simultaneous increment.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_arb_pkg contains:
  - ADDR_W and DATA_W constants.
  - state_t enum {IDLE, ACCESS, RECOVER}.
  - cmd_t struct {we, addr, wdata}.
- Sub-module rr_picker (combinational): inputs req and last, outputs winner index and any_req.

Test Plan:
- Write then read, single requester: req0 writes addr=8'h10 data=8'hA5, then reads 8'h10 -> gnt[0] one cycle after each req, mem_rwn=0 for exactly 1 cycle, rvalid[0] with rdata=8'hA5 two cycles after the read req.
- Contention: req0 and req1 held high together for 6 accesses -> grant order 0,1,0,1,0,1, gnts spaced 3 cycles apart.
- Boundary address: req1 writes 8'hFF to addr 8'hFF, then req0 reads 8'hFF -> rdata=8'hFF with no wrap or corruption; a concurrent read of addr 8'h00 returns the prior value.
- Reset in ACCESS: assert rst_n=0 during a write cycle -> mem_rwn=1, gnt=0, rvalid=0 and busy=0 immediately; the first request after reset is granted to req0.
- No-request idle: req=0 for 20 cycles -> busy=0, mem_rwn=1, no gnt or rvalid pulses.
- Stats (RAM_ARB_STATS_EN defined): 5 grants to req1 -> grant_cnt[1]=5; stats_clr pulsed in the same cycle as a gnt -> grant_cnt=0.
